mfu_seq_fuse: RTL and testbench

//  Sequential precision-fusion wrapper around one 2x2 bit-brick multiplier (mBB).
//  - Splits W-bit operands into 2-bit bricks and drives mBB with one brick pair per cycle.
//  - Sets the per-pair signedness select.
//  - Sign/zero-extends each 4-bit brick product, shifts it into place and accumulates it into the 2W-bit product.
//  - Sits between the operand fetch stage and the MAC accumulator in the MFU.

---
 rtl/mfu_pkg.sv | 17 +
 rtl/mfu_seq_fuse_mbb.sv | 21 ++
 rtl/mfu_seq_fuse.sv | 104 ++++++++++
 tb/tb_mfu_seq_fuse.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mfu_pkg.sv
// rtl/mfu_pkg.sv - shared encodings for the sequential precision-fusion multiplier
package mfu_pkg;

  typedef enum logic [1:0] {
    SEL_UU = 2'b00,
    SEL_US = 2'b01,
    SEL_SU = 2'b10,
    SEL_SS = 2'b11
  } sel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/mfu_seq_fuse_mbb.sv
// rtl/mfu_seq_fuse_mbb.sv - combinational 2x2 bit-brick multiplier with per-operand signedness
module mfu_seq_fuse_mbb (
  input  logic [1:0] ab,
  input  logic [1:0] bb,
  input  logic [1:0] sel,
  output logic [3:0] p
);

  logic       sa;
  logic       sb;
  logic [3:0] ae;
  logic [3:0] be;

  // Widening both bricks to 4 bits makes the low 4 product bits exact in every sign mode.
  assign sa = sel[1] & ab[1];
  assign sb = sel[0] & bb[1];
  assign ae = {sa, sa, ab};
  assign be = {sb, sb, bb};
  assign p  = ae * be;

endmodule

// File: rtl/mfu_seq_fuse.sv
// rtl/mfu_seq_fuse.sv - feeds one brick pair per cycle to mBB and accumulates the shifted partials
module mfu_seq_fuse
  import mfu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           nrst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           a_signed,
  input  logic           b_signed,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] p
);

  localparam int N  = W / 2;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = 2 * W;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_e        state;
  state_e        state_nxt;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic          as_q;
  logic          bs_q;
  logic [CW-1:0] i_q;
  logic [CW-1:0] j_q;
  logic [PW-1:0] acc;
  logic          i_last;
  logic          j_last;
  logic [1:0]    ab;
  logic [1:0]    bb;
  logic [1:0]    sel;
  logic [3:0]    bp;
  logic [PW-1:0] ext;
  logic [CW:0]   ij;
  logic [PW-1:0] term;

  assign i_last = (i_q == LAST);
  assign j_last = (j_q == LAST);
  assign ab     = a_q[{i_q, 1'b0} +: 2];
  assign bb     = b_q[{j_q, 1'b0} +: 2];
  // Only the top brick of a signed operand carries the sign weight.
  assign sel    = {as_q & i_last, bs_q & j_last};

  mfu_seq_fuse_mbb u_mbb (
    .ab  (ab),
    .bb  (bb),
    .sel (sel),
    .p   (bp)
  );

  assign ext  = (sel != SEL_UU) ? PW'($signed(bp)) : PW'(bp);
  assign ij   = {1'b0, i_q} + {1'b0, j_q};
  assign term = ext << {ij, 1'b0};

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid) state_nxt = ST_RUN;
      ST_RUN:  if (i_last && j_last) state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= ST_IDLE;
      a_q   <= '0;
      b_q   <= '0;
      as_q  <= 1'b0;
      bs_q  <= 1'b0;
      i_q   <= '0;
      j_q   <= '0;
      acc   <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && in_valid) begin
        a_q  <= a;
        b_q  <= b;
        as_q <= a_signed;
        bs_q <= b_signed;
        i_q  <= '0;
        j_q  <= '0;
        acc  <= '0;
      end else if (state == ST_RUN) begin
        acc <= acc + term;
        i_q <= i_last ? '0 : i_q + 1'b1;
        if (i_last) j_q <= j_last ? '0 : j_q + 1'b1;
      end
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign p         = acc;

endmodule

// File: tb/tb_mfu_seq_fuse.sv
// tb/tb_mfu_seq_fuse.sv - self-checking bench for mfu_seq_fuse at W=8
module tb_mfu_seq_fuse;

  localparam int W   = 8;
  localparam int LAT = (W / 2) * (W / 2) + 1;
  localparam int NR  = 2000;

  logic         clk = 1'b0;
  logic         nrst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         a_signed;
  logic         b_signed;
  logic         out_valid;
  logic         out_ready;
  logic [2*W-1:0] p;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mfu_seq_fuse #(.W(W)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .a_signed  (a_signed),
    .b_signed  (b_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p)
  );

  function automatic logic [15:0] model(logic [7:0] x, logic [7:0] y, logic xs, logic ys);
    longint vx;
    longint vy;
    vx = xs ? longint'($signed(x)) : longint'(x);
    vy = ys ? longint'($signed(y)) : longint'(y);
    return 16'(vx * vy);
  endfunction

  task automatic accept_op(input logic [7:0] ta, input logic [7:0] tb, input logic tas, input logic tbs);
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    in_valid = 1'b1; a = ta; b = tb; a_signed = tas; b_signed = tbs;
    @(negedge clk);
    in_valid = 1'b0; a = ~ta; b = ~tb; a_signed = ~tas; b_signed = ~tbs;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; a_signed = 1'b0; b_signed = 1'b0;
    #2;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (p !== 16'h0) begin bad++; $display("FAIL reset_p got=%h want=0000", p); end
    @(negedge clk); @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic test_directed();
    logic [7:0]  va [5] = '{8'hFF, 8'h80, 8'h7F, 8'hFF, 8'd200};
    logic [7:0]  vb [5] = '{8'hFF, 8'h80, 8'h80, 8'hFF, 8'hFD};
    logic        vas[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic        vbs[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [15:0] ve [5] = '{16'hFE01, 16'h4000, 16'hC080, 16'hFF01, 16'hFDA8};
    int lat;
    for (int n = 0; n < 5; n++) begin
      accept_op(va[n], vb[n], vas[n], vbs[n]);
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL dir%0d_run_in_ready got=%b want=0", n, in_ready); end
      wait_out(lat);
      total++; if (lat != LAT) begin bad++; $display("FAIL dir%0d_latency got=%0d want=%0d", n, lat, LAT); end
      total++; if (p !== ve[n]) begin bad++; $display("FAIL dir%0d_p got=%h want=%h", n, p, ve[n]); end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL dir%0d_back_idle got=%b want=1", n, in_ready); end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    accept_op(8'hFF, 8'hFF, 1'b0, 1'b0);
    wait_out(lat);
    for (int k = 0; k < 5; k++) begin
      total++; if (out_valid !== 1'b1 || p !== 16'hFE01) begin
        bad++; $display("FAIL bp_hold%0d got=%b/%h want=1/fe01", k, out_valid, p);
      end
      in_valid = (k == 2); a = 8'h03; b = 8'h05;
      @(negedge clk);
    end
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || p !== 16'hFE01) begin
      bad++; $display("FAIL bp_after_pulse got=%b/%h want=1/fe01", out_valid, p);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_no_accept got=%b want=1", in_ready); end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    bit rose;
    accept_op(8'hA5, 8'h5A, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) @(negedge clk);
    nrst = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || p !== 16'h0) begin
      bad++; $display("FAIL midrun_reset got=%b/%b/%h want=0/1/0000", out_valid, in_ready, p);
    end
    @(negedge clk);
    nrst = 1'b1;
    rose = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (out_valid) rose = 1'b1;
    end
    total++; if (rose) begin bad++; $display("FAIL midrun_no_output got=1 want=0"); end
    accept_op(8'd3, 8'd5, 1'b0, 1'b0);
    wait_out(lat);
    total++; if (lat != LAT || p !== 16'h000F) begin
      bad++; $display("FAIL post_reset_op got=%0d/%h want=%0d/000f", lat, p, LAT);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic        ras;
    logic        rbs;
    logic [15:0] exp;
    bit          hs;
    for (int n = 0; n < NR; n++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      ras = 1'($urandom); rbs = 1'($urandom);
      exp = model(ra, rb, ras, rbs);
      accept_op(ra, rb, ras, rbs);
      hs = 1'b0;
      for (int k = 0; k < 80 && !hs; k++) begin
        out_ready = 1'($urandom_range(0, 1));
        in_valid  = 1'($urandom_range(0, 1));
        a = 8'($urandom); b = 8'($urandom);
        a_signed = 1'($urandom); b_signed = 1'($urandom);
        if (out_valid && out_ready) begin
          hs = 1'b1;
          in_valid = 1'b0;
          total++;
          if (p !== exp) begin
            bad++;
            $display("FAIL rand%0d a=%h b=%h s=%b%b got=%h want=%h", n, ra, rb, ras, rbs, p, exp);
          end
        end else begin
          @(negedge clk);
        end
      end
      if (!hs) begin
        total++; bad++;
        in_valid = 1'b0;
        $display("FAIL rand%0d_timeout got=no_handshake want=handshake", n);
      end
    end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
